bfm_apb_slave_mem: RTL
======================

# bfm_apb_slave_mem

Simulation/synthesisable APB3 slave memory model that sits directly downstream of the AHB-Lite/APB bus functional model's APB master port, terminating one PSEL line. It services reads and writes to a word-addressed RAM and inserts a programmable number of wait states. It also signals PSLVERR on misaligned or out-of-range accesses and keeps saturating transfer counters and a sticky protocol-violation flag for testbench checking.

## Interface
Parameters:
- AWIDTH, 10: word-address width; RAM depth = 2**AWIDTH words of 32 bits.
- WAIT_STATES, 0: PREADY-low cycles inserted in every access phase (0..15).
- CNT_WIDTH, 16: width of the transfer/error counters.

Ports:
- PCLK  in  1  the single clock; all state updates on its rising edge.
- PRESETN  in  1  asynchronous, active-low reset.
- PSEL  in  1  slave select (one bit of the master's PSEL bus).
- PENABLE  in  1  APB access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data, valid when PREADY=1 on a read.
- PREADY  out  1  transfer completion.
- PSLVERR  out  1  error response, valid only with PREADY=1.
- WR_COUNT  out  CNT_WIDTH  completed error-free writes, saturating.
- RD_COUNT  out  CNT_WIDTH  completed error-free reads, saturating.
- ERR_COUNT  out  CNT_WIDTH  transfers completed with PSLVERR=1, saturating.
- PROT_ERR  out  1  sticky; set on an APB protocol violation.

## Operation
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS on a setup phase (PSEL=1, PENABLE=0).
  - ACCESS -> IDLE on the completing cycle (PSEL=1, PENABLE=1, PREADY=1).
- Wait counter:
  - Loads WAIT_STATES in the setup cycle.
  - Decrements each ACCESS cycle while nonzero.
  - PREADY = PSEL & PENABLE & (state==ACCESS) & (count==0), combinational from registered state.
- Address decode is evaluated in the setup cycle and registered.
  - Error if PADDR[1:0]!=0 or PADDR[31:AWIDTH+2]!=0.
  - Index = PADDR[AWIDTH+1:2].
- Read:
  - PRDATA is registered in the setup cycle from RAM[index], or 0 on error.
  - PRDATA holds until the next setup phase.
- Write: RAM[index] <= PWDATA on the completing cycle, only if there is no error. Errored writes leave the RAM unchanged.
- PSLVERR = PREADY & registered error. It is 0 at all other times.
- Counters:
  - On each completing cycle, exactly one of WR_COUNT/RD_COUNT/ERR_COUNT increments.
  - Each counter stops at all-ones.
- PROT_ERR is set, and stays set until reset, on any of:
  - PENABLE=1 while state==IDLE.
  - PSEL deasserted while in ACCESS before PREADY.
  - PADDR, PWRITE or PWDATA changing between setup and completion.
  - On PSEL dropping, the FSM returns to IDLE and the transfer is abandoned without a RAM write.
- Back-to-back transfers: a setup phase in the cycle after completion is accepted normally.

## Timing
- Reset values:
  - PRDATA=0, PREADY=0, PSLVERR=0, PROT_ERR=0.
  - All counters 0; state IDLE; wait count 0.
- RAM contents are zero at time 0 and are not affected by PRESETN.
- Latency with WAIT_STATES=N:
  - Completion on access-phase cycle N+1.
  - Total transfer is N+2 PCLK cycles including setup.
- Reset asserted mid-transfer:
  - Outputs go to reset values immediately (asynchronously).
  - A pending write is discarded.
  - After PRESETN rises, the master restarts the transfer with a new setup phase.
- Counters and RAM update on the same edge that ends the completing cycle. New values are visible in the following cycle.

## Structure
- Package bfm_apb_slave_pkg:
  - FSM state enum (IDLE, ACCESS).
  - Widths of the error-reason encoding.
  - Constant APB_WORD_BYTES=4.
- Sub-module bfm_apb_slave_ram:
  - 2**AWIDTH x 32 single-port array.
  - Write enable and index in; asynchronous read data out.
- Top level holds the FSM, wait counter, decode, counters and protocol checker.

## Test plan
- WAIT_STATES=0: write 0xDEADBEEF to 0x10, then read 0x10 -> each transfer takes 2 cycles, PRDATA=0xDEADBEEF, PSLVERR=0, WR_COUNT=1, RD_COUNT=1.
- WAIT_STATES=3: read 0x40 after reset -> PREADY low for 3 access cycles and high on the 4th, PRDATA=0.
- Write to 0x12 (misaligned), then read 0x10 -> write completes with PSLVERR=1, ERR_COUNT=1, and 0x10 still holds its previous value.
- AWIDTH=10: write to 0x1000 -> PSLVERR=1; a read of 0x1000 returns PRDATA=0 with PSLVERR=1; ERR_COUNT=2.
- Drive PENABLE=1 with no preceding setup phase -> PROT_ERR=1 the next cycle and stays set; no counter changes.
- WAIT_STATES=2: assert PRESETN=0 during a write's second wait cycle -> PREADY=0 immediately, counters 0, target word unchanged.
- CNT_WIDTH=4: run 20 reads -> RD_COUNT saturates at 15.

Source files
------------

// File: rtl/bfm_apb_slave_pkg.sv
// Shared types and helpers for the APB3 slave memory model.
package bfm_apb_slave_pkg;

  // Bytes per RAM word; byte addresses must be a multiple of this.
  localparam int unsigned APB_WORD_BYTES = 4;

  // Width of the error-reason encoding kept alongside each transfer.
  localparam int unsigned ERR_REASON_W = 2;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  typedef enum logic [ERR_REASON_W-1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2
  } err_reason_e;

  // Classifies a byte address: misalignment wins over out-of-range.
  function automatic err_reason_e decode_err(input logic [31:0] paddr,
                                             input int unsigned awidth);
    logic [31:0] lane_mask;
    logic [31:0] above;
    lane_mask = 32'(APB_WORD_BYTES - 1);
    above     = paddr >> (awidth + $clog2(APB_WORD_BYTES));
    if ((paddr & lane_mask) != 32'd0) return ERR_MISALIGN;
    if (above != 32'd0)               return ERR_RANGE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/bfm_apb_slave_ram.sv
// Word-addressed single-port RAM: synchronous write, asynchronous read.
module bfm_apb_slave_ram #(
  parameter int unsigned AWIDTH = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] idx_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  localparam int unsigned DEPTH = 1 << AWIDTH;

  // NOTE: the array has no reset branch; contents start at zero and must
  // survive a bus reset, and a reset port would also block RAM inference.
  logic [31:0] mem_q [DEPTH] = '{default: '0};

  // Store the write word on the completing edge.
  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/bfm_apb_slave_mem.sv
// APB3 slave memory model: wait-state insertion, address-error response,
// saturating transfer counters and a sticky protocol-violation flag.
module bfm_apb_slave_mem
  import bfm_apb_slave_pkg::*;
#(
  parameter int unsigned AWIDTH      = 10,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETN,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [31:0]          PADDR,
  input  logic [31:0]          PWDATA,
  output logic [31:0]          PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic [CNT_WIDTH-1:0] WR_COUNT,
  output logic [CNT_WIDTH-1:0] RD_COUNT,
  output logic [CNT_WIDTH-1:0] ERR_COUNT,
  output logic                 PROT_ERR
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  apb_state_e           state_q,   state_d;
  logic [3:0]           wait_q,    wait_d;
  err_reason_e          reason_q,  reason_d;
  logic [31:0]          paddr_q,   paddr_d;
  logic                 pwrite_q,  pwrite_d;
  logic [31:0]          pwdata_q,  pwdata_d;
  logic [31:0]          prdata_q,  prdata_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q,  wr_cnt_d;
  logic [CNT_WIDTH-1:0] rd_cnt_q,  rd_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                 prot_q,    prot_d;

  logic              in_access;
  logic              setup;
  logic              ready;
  logic              xfer_err;
  logic              violation;
  err_reason_e       setup_reason;
  logic [AWIDTH-1:0] setup_idx;
  logic [AWIDTH-1:0] ram_idx;
  logic              ram_we;
  logic [31:0]       ram_rdata;

  assign in_access    = (state_q == ST_ACCESS);
  assign setup        = PSEL & ~PENABLE;
  assign ready        = PSEL & PENABLE & in_access & (wait_q == 4'd0);
  assign xfer_err     = (reason_q != ERR_NONE);
  assign setup_reason = decode_err(PADDR, AWIDTH);
  assign setup_idx    = PADDR[AWIDTH+1:2];

  // The single RAM port reads the new address during setup and writes the
  // captured address during the access phase.
  assign ram_idx = in_access ? paddr_q[AWIDTH+1:2] : setup_idx;
  assign ram_we  = ready & pwrite_q & ~xfer_err;

  bfm_apb_slave_ram #(
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk_i   (PCLK),
    .we_i    (ram_we),
    .idx_i   (ram_idx),
    .wdata_i (PWDATA),
    .rdata_o (ram_rdata)
  );

  // Any change of the captured address/control/data mid-transfer, a dropped
  // select during the access phase, or PENABLE outside a transfer.
  assign violation = (~in_access & PENABLE)
                   | (in_access & ~PSEL)
                   | (in_access & PSEL & ((PADDR  != paddr_q)  |
                                          (PWRITE != pwrite_q) |
                                          (PWDATA != pwdata_q)));

  // FSM, wait counter and setup-phase capture of address, decode and read data.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d  = state_q;
    wait_d   = wait_q;
    reason_d = reason_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    prdata_d = prdata_q;
    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          state_d  = ST_ACCESS;
          wait_d   = WAIT_INIT;
          reason_d = setup_reason;
          paddr_d  = PADDR;
          pwrite_d = PWRITE;
          pwdata_d = PWDATA;
          prdata_d = (setup_reason == ERR_NONE) ? ram_rdata : 32'd0;
        end
      end
      ST_ACCESS: begin
        if (!PSEL || ready) state_d = ST_IDLE;
        if (wait_q != 4'd0) wait_d = wait_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating completion counters and the sticky protocol flag.
  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    err_cnt_d = err_cnt_q;
    prot_d    = prot_q | violation;
    if (ready) begin
      if (xfer_err) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      end else if (pwrite_q) begin
        if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 1'b1;
      end else begin
        if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end
  end

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q   <= ST_IDLE;
      wait_q    <= 4'd0;
      reason_q  <= ERR_NONE;
      paddr_q   <= 32'd0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= 32'd0;
      prdata_q  <= 32'd0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
      prot_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      reason_q  <= reason_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      prdata_q  <= prdata_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_cnt_q <= err_cnt_d;
      prot_q    <= prot_d;
    end
  end

  assign PRDATA    = prdata_q;
  assign PREADY    = ready;
  assign PSLVERR   = ready & xfer_err;
  assign WR_COUNT  = wr_cnt_q;
  assign RD_COUNT  = rd_cnt_q;
  assign ERR_COUNT = err_cnt_q;
  assign PROT_ERR  = prot_q;

endmodule
